// File: rtl/serial_subtractor_pkg.sv
`default_nettype none
// ============================================================================
// Package     : serial_subtractor_pkg
// Description : State encoding and sizing helpers shared by the bit-serial
//               subtractor and its full-subtractor cell.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_subtractor_pkg;

  // Controller states, 2-bit encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Width of one full-subtractor column (single bit per clock)
  localparam int FS_BITS = 1;

  // Bit-counter width able to hold 0..N
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_subtractor_full_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor_full_subtractor
// Description : One-bit full subtractor, d = a - b - br_in with borrow out.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor_full_subtractor (
  input  logic a_i,
  input  logic b_i,
  input  logic br_i,
  output logic d_o,
  output logic br_o
);

  // Difference bit and borrow generated by this column
  assign d_o  = a_i ^ b_i ^ br_i;
  assign br_o = (~a_i & b_i) | (~(a_i ^ b_i) & br_i);

endmodule
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor
// Description : Bit-serial N-bit subtractor, {b_out, diff} = a - b - b_in,
//               LSB first, one bit per clock, start/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         b_in,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] diff,
  output logic         b_out
);

  localparam int CW = cnt_width(N);

  state_e        state_q, state_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic [N-1:0]  wd_q, wd_d;
  logic          br_q, br_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  diff_q, diff_d;
  logic          bout_q, bout_d;

  logic          w_d;
  logic          w_br;
  logic [N:0]    w_wd_cat;

  serial_subtractor_full_subtractor u_fs (
    .a_i  (a_q[0]),
    .b_i  (b_q[0]),
    .br_i (br_q),
    .d_o  (w_d),
    .br_o (w_br)
  );

  // New difference bit enters at the MSB; bits [N:1] form the shifted word
  assign w_wd_cat = {w_d, wd_q};

  // Next-state, datapath update and output-register load
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    wd_d    = wd_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          br_d    = b_in;
          wd_d    = '0;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        wd_d  = w_wd_cat[N:1];
        br_d  = w_br;
        cnt_d = cnt_q + CW'(1);
        // Output regs load on the last column so they are valid while done is high
        if (cnt_q == CW'(N - 1)) begin
          diff_d  = w_wd_cat[N:1];
          bout_d  = w_br;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, working and output registers; reset aborts any operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      wd_q    <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      wd_q    <= wd_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
    end
  end

  assign busy  = (state_q == ST_SHIFT);
  assign done  = (state_q == ST_DONE);
  assign diff  = diff_q;
  assign b_out = bout_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_subtractor
// Description : Self-checking bench for serial_subtractor at N = 1, 4 and 8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       st1 = 1'b0, a1 = 1'b0, b1 = 1'b0, bi1 = 1'b0;
  logic       busy1, done1, diff1, bo1;
  logic       st4 = 1'b0, bi4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy4, done4, bo4;
  logic [3:0] diff4;
  logic       st8 = 1'b0, bi8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, bo8;
  logic [7:0] diff8;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.N(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(st1), .a(a1), .b(b1), .b_in(bi1),
    .busy(busy1), .done(done1), .diff(diff1), .b_out(bo1)
  );
  serial_subtractor #(.N(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(st4), .a(a4), .b(b4), .b_in(bi4),
    .busy(busy4), .done(done4), .diff(diff4), .b_out(bo4)
  );
  serial_subtractor #(.N(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(st8), .a(a8), .b(b8), .b_in(bi8),
    .busy(busy8), .done(done8), .diff(diff8), .b_out(bo8)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int n, input logic s, input logic [7:0] av,
                       input logic [7:0] bv, input logic bi);
    case (n)
      1: begin st1 = s; a1 = av[0];   b1 = bv[0];   bi1 = bi; end
      4: begin st4 = s; a4 = av[3:0]; b4 = bv[3:0]; bi4 = bi; end
      default: begin st8 = s; a8 = av; b8 = bv; bi8 = bi; end
    endcase
  endtask

  function automatic logic rd_busy(input int n);
    return (n == 1) ? busy1 : (n == 4) ? busy4 : busy8;
  endfunction
  function automatic logic rd_done(input int n);
    return (n == 1) ? done1 : (n == 4) ? done4 : done8;
  endfunction
  function automatic logic rd_bout(input int n);
    return (n == 1) ? bo1 : (n == 4) ? bo4 : bo8;
  endfunction
  function automatic logic [7:0] rd_diff(input int n);
    return (n == 1) ? {7'b0, diff1} : (n == 4) ? {4'b0, diff4} : diff8;
  endfunction

  // One full operation: start in IDLE, N busy cycles, one done cycle, back to IDLE.
  // With hold set, start stays high with fresh junk operands every cycle.
  task automatic run_op(input int n, input logic [7:0] av_in, input logic [7:0] bv_in,
                        input logic bi, input bit hold);
    int av, bv, full, mask, exp_diff, exp_bo, sum;
    mask     = (1 << n) - 1;
    av       = int'(av_in) & mask;
    bv       = int'(bv_in) & mask;
    full     = av - bv - int'(bi);
    exp_diff = full & mask;
    exp_bo   = (av < bv + int'(bi)) ? 1 : 0;
    drive(n, 1'b1, 8'(av), 8'(bv), bi);
    step();
    for (int k = 0; k < n; k++) begin
      chk("busy_high", 32'(rd_busy(n)), 32'd1);
      chk("done_low_busy", 32'(rd_done(n)), 32'd0);
      drive(n, logic'(hold), 8'($urandom), 8'($urandom), 1'($urandom));
      step();
    end
    chk("done_pulse", 32'(rd_done(n)), 32'd1);
    chk("busy_low_done", 32'(rd_busy(n)), 32'd0);
    chk("diff", 32'(rd_diff(n)), 32'(exp_diff));
    chk("b_out", 32'(rd_bout(n)), 32'(exp_bo));
    sum = (int'(rd_diff(n)) + bv + int'(bi)) & ((1 << (n + 1)) - 1);
    chk("adder_inverse", 32'(sum), 32'((int'(rd_bout(n)) << n) | av));
    step();
    chk("done_one_cycle", 32'(rd_done(n)), 32'd0);
    chk("diff_hold", 32'(rd_diff(n)), 32'(exp_diff));
  endtask

  // Directed and randomized sequence
  initial begin
    rst_n = 1'b0;
    step();
    step();
    chk("rst_busy4", 32'(busy4), 32'd0);
    chk("rst_done4", 32'(done4), 32'd0);
    chk("rst_diff4", 32'(diff4), 32'd0);
    chk("rst_bout4", 32'(bo4), 32'd0);
    chk("rst_diff8", 32'(diff8), 32'd0);
    chk("rst_diff1", 32'(diff1), 32'd0);
    rst_n = 1'b1;
    step();

    // Directed N=4 cases
    run_op(4, 8'd9,  8'd3,  1'b0, 1'b0);
    run_op(4, 8'd3,  8'd9,  1'b0, 1'b0);
    run_op(4, 8'd0,  8'd0,  1'b1, 1'b0);
    run_op(4, 8'd15, 8'd15, 1'b1, 1'b0);
    run_op(4, 8'd15, 8'd0,  1'b0, 1'b0);

    // Start held high, operands churning: back-to-back ops every N+2 cycles
    for (int i = 0; i < 6; i++)
      run_op(4, 8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
    drive(4, 1'b0, 8'd0, 8'd0, 1'b0);
    step();
    chk("idle_no_start", 32'(busy4), 32'd0);

    // Reset in the second SHIFT cycle aborts the operation
    run_op(4, 8'd9, 8'd3, 1'b0, 1'b0);
    drive(4, 1'b1, 8'd5, 8'd2, 1'b0);
    step();
    drive(4, 1'b0, 8'd0, 8'd0, 1'b0);
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy4), 32'd0);
    chk("abort_done", 32'(done4), 32'd0);
    chk("abort_diff", 32'(diff4), 32'd0);
    chk("abort_bout", 32'(bo4), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("abort_no_done", 32'(done4), 32'd0);
    end
    rst_n = 1'b1;
    step();
    chk("post_reset_idle_done", 32'(done4), 32'd0);
    run_op(4, 8'd12, 8'd5, 1'b1, 1'b0);

    // N=1 exhaustive sweep
    for (int v = 0; v < 8; v++)
      run_op(1, 8'(v & 1), 8'((v >> 1) & 1), 1'((v >> 2) & 1), 1'b0);

    // N=8 boundary cases
    run_op(8, 8'd0,   8'd255, 1'b1, 1'b0);
    run_op(8, 8'd255, 8'd254, 1'b1, 1'b0);

    // Randomized operations
    for (int i = 0; i < 1000; i++)
      run_op(4, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
    for (int i = 0; i < 1000; i++)
      run_op(8, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
